// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and the buffered fetch entry type for the frontend.
package fetch_pkg;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } FetchEntry_t;
endpackage

// File: rtl/inst_fifo_ptr.sv
// inst_fifo_ptr: wrap-bit read/write pointers, full/empty, occupancy and write acceptance.
module inst_fifo_ptr #(
    parameter int DEPTH = 4,
    localparam int PTR = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    output logic         wr_en,
    output logic         ovf,
    output logic [PTR-1:0] wr_idx,
    output logic [PTR-1:0] rd_idx,
    output logic         empty,
    output logic [PTR:0] cnt
);
    localparam logic [PTR:0] ONE = 1;
    logic [PTR:0] wr_ptr, rd_ptr;
    logic full, rd_en;
    assign wr_idx = wr_ptr[PTR-1:0];
    assign rd_idx = rd_ptr[PTR-1:0];
    assign empty  = wr_ptr == rd_ptr;
    assign full   = (wr_idx == rd_idx) && (wr_ptr[PTR] != rd_ptr[PTR]);
    assign cnt    = wr_ptr - rd_ptr;
    // a full queue still takes a write when the head leaves in the same cycle
    assign wr_en  = push && (!full || pop) && !flush;
    assign rd_en  = pop && !flush;
    assign ovf    = push && full && !pop && !flush;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ONE;
            if (rd_en) rd_ptr <= rd_ptr + ONE;
        end
    end
endmodule

// File: rtl/fetch_inst_buf.sv
// fetch_inst_buf: circular instruction buffer between I-cache fetch and decode,
// with registered back-pressure and flush-to-empty.
module fetch_inst_buf
    import fetch_pkg::*;
#(
    parameter int ADDR  = ADDR_W,
    parameter int INST  = INST_W,
    parameter int DEPTH = 4,
    parameter int PTR   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inst_e_,
    input  logic [ADDR-1:0] inst_pc,
    input  logic            ic_stall,
    input  logic [INST-1:0] ic_inst,
    output logic            buf_stall,
    input  logic            dec_stop,
    input  logic            dec_busy,
    output logic            dec_e_,
    output logic [ADDR-1:0] dec_pc,
    output logic [INST-1:0] dec_inst,
    input  logic            br_flush_,
    input  logic            flush_,
    output logic [PTR:0]    buf_cnt,
    output logic            ovf_err
);
    localparam logic [PTR:0] STALL_LVL = (PTR+1)'(DEPTH - 1);
    FetchEntry_t mem [DEPTH];
    logic push, pop, flush, wr_en, ovf, empty;
    logic [PTR-1:0] wr_idx, rd_idx;
    assign push   = !inst_e_ && !ic_stall;
    assign flush  = !br_flush_ || !flush_;
    assign dec_e_ = empty || dec_stop;
    assign pop    = !dec_e_ && !dec_busy;
    // one slot of headroom covers the access already in flight in fetch control
    assign buf_stall = buf_cnt >= STALL_LVL;
    assign dec_pc    = mem[rd_idx].pc;
    assign dec_inst  = mem[rd_idx].inst;
    inst_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .wr_en  (wr_en),
        .ovf    (ovf),
        .wr_idx (wr_idx),
        .rd_idx (rd_idx),
        .empty  (empty),
        .cnt    (buf_cnt)
    );
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= '{pc: inst_pc, inst: ic_inst};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_err <= 1'b0;
        else if (ovf) ovf_err <= 1'b1;
    end
endmodule

// File: tb/tb_fetch_inst_buf.sv
// tb_fetch_inst_buf: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_inst_buf;
    import fetch_pkg::*;
    localparam int DEPTH = 4;
    logic clk = 0, reset = 1, inst_e_ = 1, ic_stall = 0, dec_stop = 0, dec_busy = 0;
    logic br_flush_ = 1, flush_ = 1;
    logic [31:0] inst_pc = 0, ic_inst = 0;
    logic buf_stall, dec_e_, ovf_err;
    logic [31:0] dec_pc, dec_inst;
    logic [2:0] buf_cnt;
    logic [63:0] q[$];
    bit m_ovf;
    int checks = 0, errors = 0;

    fetch_inst_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .inst_e_(inst_e_), .inst_pc(inst_pc), .ic_stall(ic_stall),
        .ic_inst(ic_inst), .buf_stall(buf_stall), .dec_stop(dec_stop), .dec_busy(dec_busy),
        .dec_e_(dec_e_), .dec_pc(dec_pc), .dec_inst(dec_inst), .br_flush_(br_flush_),
        .flush_(flush_), .buf_cnt(buf_cnt), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] pc);
        inst_e_ = 0; ic_stall = 0; inst_pc = pc; ic_inst = $urandom;
    endtask

    task automatic idle();
        inst_e_ = 1;
    endtask

    // advance one clock, updating the model from the inputs present before the edge
    task automatic cycle();
        bit fl, ps, pp, full;
        fl = !br_flush_ || !flush_;
        ps = !inst_e_ && !ic_stall;
        pp = !(q.size() == 0 || dec_stop) && !dec_busy;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            full = q.size() == DEPTH;
            if (pp) void'(q.pop_front());
            if (ps) begin
                if (!full || pp) q.push_back({inst_pc, ic_inst});
                else m_ovf = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        @(posedge clk); #1;
        checks++; if (dec_e_ !== 1'b1) begin errors++; $display("FAIL reset_dec_e got %b want 1", dec_e_); end
        checks++; if (buf_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", buf_stall); end
        checks++; if (buf_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", buf_cnt); end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_err); end
        #3 reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        dec_busy = 0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h100 + 32'(4*i));
            cycle();
            checks++; if (dec_e_ !== 1'b0 || dec_pc !== 32'h100 + 32'(4*i) || dec_inst !== q[0][31:0])
                begin errors++; $display("FAIL stream_out[%0d] got e=%b pc=%h inst=%h want e=0 pc=%h", i, dec_e_, dec_pc, dec_inst, 32'h100 + 32'(4*i)); end
            checks++; if (buf_cnt > 3'd1) begin errors++; $display("FAIL stream_cnt[%0d] got %0d want <=1", i, buf_cnt); end
        end
        idle();
        cycle();
        checks++; if (dec_e_ !== 1'b1 || buf_cnt !== 3'd0) begin errors++; $display("FAIL stream_empty got e=%b cnt=%0d want e=1 cnt=0", dec_e_, buf_cnt); end
    endtask

    task automatic test_backpressure();
        dec_busy = 1;
        for (int i = 0; i < 4; i++) begin
            drive(32'h200 + 32'(4*i));
            cycle();
            checks++; if (buf_cnt !== 3'(i+1) || buf_stall !== (i >= 2)) begin errors++; $display("FAIL bp_fill[%0d] got cnt=%0d stall=%b want cnt=%0d stall=%b", i, buf_cnt, buf_stall, i+1, i >= 2); end
        end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL bp_no_ovf got %b want 0", ovf_err); end
        idle();
        dec_busy = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (dec_e_ !== 1'b0 || dec_pc !== 32'h200 + 32'(4*i)) begin errors++; $display("FAIL bp_drain[%0d] got e=%b pc=%h want pc=%h", i, dec_e_, dec_pc, 32'h200 + 32'(4*i)); end
            cycle();
        end
        checks++; if (dec_e_ !== 1'b1 || buf_stall !== 1'b0) begin errors++; $display("FAIL bp_end got e=%b stall=%b want e=1 stall=0", dec_e_, buf_stall); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp[4] = '{32'h504, 32'h508, 32'h50C, 32'h300};
        dec_busy = 1;
        for (int i = 0; i < 4; i++) begin drive(32'h500 + 32'(4*i)); cycle(); end
        dec_busy = 0;
        drive(32'h300);
        cycle();
        checks++; if (buf_cnt !== 3'd4 || dec_pc !== 32'h504) begin errors++; $display("FAIL full_pp got cnt=%0d pc=%h want cnt=4 pc=504", buf_cnt, dec_pc); end
        dec_busy = 1;
        drive(32'h600);
        cycle();
        idle();
        cycle();
        checks++; if (ovf_err !== 1'b1 || buf_cnt !== 3'd4) begin errors++; $display("FAIL full_ovf got ovf=%b cnt=%0d want ovf=1 cnt=4", ovf_err, buf_cnt); end
        dec_busy = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (dec_pc !== exp[i] || dec_e_ !== 1'b0) begin errors++; $display("FAIL full_drain[%0d] got pc=%h want %h", i, dec_pc, exp[i]); end
            cycle();
        end
        checks++; if (ovf_err !== 1'b1 || dec_e_ !== 1'b1) begin errors++; $display("FAIL full_sticky got ovf=%b e=%b want ovf=1 e=1", ovf_err, dec_e_); end
    endtask

    task automatic test_flush(input bit frontend);
        dec_busy = 1;
        for (int i = 0; i < 3; i++) begin drive(32'h380 + 32'(4*i)); cycle(); end
        checks++; if (buf_cnt !== 3'd3) begin errors++; $display("FAIL flush%0d_pre got cnt=%0d want 3", frontend, buf_cnt); end
        br_flush_ = !frontend; flush_ = frontend;
        drive(32'h3FC);
        cycle();
        br_flush_ = 1; flush_ = 1;
        checks++; if (buf_cnt !== 3'd0 || dec_e_ !== 1'b1 || ovf_err !== 1'b1) begin errors++; $display("FAIL flush%0d_clear got cnt=%0d e=%b ovf=%b want 0 1 1", frontend, buf_cnt, dec_e_, ovf_err); end
        dec_busy = 0;
        drive(32'h400);
        cycle();
        idle();
        checks++; if (dec_e_ !== 1'b0 || dec_pc !== 32'h400) begin errors++; $display("FAIL flush%0d_next got e=%b pc=%h want pc=400", frontend, dec_e_, dec_pc); end
        cycle();
    endtask

    task automatic test_dec_stop();
        dec_stop = 1; dec_busy = 0;
        for (int i = 0; i < 2; i++) begin
            drive(32'h800 + 32'(4*i));
            cycle();
            checks++; if (dec_e_ !== 1'b1) begin errors++; $display("FAIL stop_hold[%0d] got e=%b want 1", i, dec_e_); end
        end
        idle();
        checks++; if (buf_cnt !== 3'd2) begin errors++; $display("FAIL stop_cnt got %0d want 2", buf_cnt); end
        dec_stop = 0;
        #1;
        checks++; if (dec_e_ !== 1'b0 || dec_pc !== 32'h800) begin errors++; $display("FAIL stop_release got e=%b pc=%h want pc=800", dec_e_, dec_pc); end
        cycle();
        cycle();
    endtask

    task automatic test_reset_mid();
        dec_busy = 1;
        for (int i = 0; i < 3; i++) begin drive(32'h900 + 32'(4*i)); cycle(); end
        idle();
        checks++; if (buf_cnt !== 3'd3 || ovf_err !== 1'b1) begin errors++; $display("FAIL rmid_pre got cnt=%0d ovf=%b want 3 1", buf_cnt, ovf_err); end
        #2 reset = 1;
        #1;
        checks++; if (dec_e_ !== 1'b1 || buf_stall !== 1'b0 || buf_cnt !== 3'd0 || ovf_err !== 1'b0)
            begin errors++; $display("FAIL rmid_async got e=%b stall=%b cnt=%0d ovf=%b want 1 0 0 0", dec_e_, buf_stall, buf_cnt, ovf_err); end
        q.delete(); m_ovf = 0;
        @(posedge clk); #3 reset = 0;
        @(posedge clk); #1;
        dec_busy = 0;
        drive(32'h700);
        cycle();
        idle();
        checks++; if (dec_e_ !== 1'b0 || dec_pc !== 32'h700) begin errors++; $display("FAIL rmid_after got e=%b pc=%h want pc=700", dec_e_, dec_pc); end
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            inst_e_   = $urandom_range(0, 2) == 0;
            ic_stall  = $urandom_range(0, 3) == 0;
            inst_pc   = $urandom;
            ic_inst   = $urandom;
            dec_busy  = $urandom_range(0, 1);
            dec_stop  = $urandom_range(0, 7) == 0;
            br_flush_ = $urandom_range(0, 19) != 0;
            flush_    = $urandom_range(0, 19) != 0;
            #1;
            checks++; if (dec_e_ !== (q.size() == 0 || dec_stop)) begin errors++; $display("FAIL rnd_dec_e[%0d] got %b", n, dec_e_); end
            checks++; if (int'(buf_cnt) !== q.size() || buf_stall !== (q.size() >= DEPTH-1)) begin errors++; $display("FAIL rnd_cnt[%0d] got cnt=%0d stall=%b want cnt=%0d", n, buf_cnt, buf_stall, q.size()); end
            checks++; if (ovf_err !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d] got %b want %b", n, ovf_err, m_ovf); end
            if (q.size() != 0) begin
                checks++; if ({dec_pc, dec_inst} !== q[0]) begin errors++; $display("FAIL rnd_data[%0d] got %h_%h want %h", n, dec_pc, dec_inst, q[0]); end
            end
            cycle();
        end
        idle(); br_flush_ = 1; flush_ = 1; dec_stop = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_full_push_pop();
        test_flush(1'b1);
        test_flush(1'b0);
        test_dec_stop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
